iir_inverse_fir: RTL and testbench
==================================

// Module: iir_inverse_fir
// PURPOSE
//  Inverse (all-zero) filter that undoes the recursive IIR stage: x[n] = y[n] - sum_{k=1..ORDER} a_k*y[n-k].
//  Sits at the receive end of the IIR path and recovers the original sample stream bit-exactly.
//  A single time-shared multiplier computes one tap per cycle under a small FSM.
//  Streaming valid/ready on input and output; coefficients are written through a register port.
// PARAMETERS
//  DATA_W  4  sample width, two's complement; also the coefficient width
//  ORDER   2  number of feedback taps inverted, 1..8; ORDER=1 inverts y=x+a*y[n-1]
//  AW      $clog2(ORDER), minimum 1   coefficient address width
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       async active-high reset
//  coef_we    in   1       coefficient write strobe
//  coef_addr  in   AW      tap index: 0 -> a_1 ... ORDER-1 -> a_ORDER
//  coef_data  in   DATA_W  coefficient value
//  in_valid   in   1       y sample present
//  in_ready   out  1       block can accept a sample (IDLE only)
//  in_data    in   DATA_W  y[n]
//  out_valid  out  1       recovered x[n] present
//  out_ready  in   1       sink accepts x[n]
//  out_data   out  DATA_W  x[n]
// BEHAVIOUR
//  Reset (async, immediate): FSM=IDLE; out_valid=0; out_data=0; in_ready=1; history y[n-1..n-ORDER]=0; coefs=0; acc=0.
//  Arithmetic: all mod 2^DATA_W. Each product a_k*y[n-k] is formed full 2*DATA_W signed; only the low DATA_W bits are used.
//   This matches the truncation in the IIR stage, so inversion is exact. Low bits are sign-independent.
//  FSM:
//   IDLE: in_ready=1. On in_valid: latch y into smp, acc<=y, k<=1 -> MAC.
//   MAC: in_ready=0. Each cycle: acc <= acc - low(a_k*hist[k]); k++.
//    After tap ORDER: out_data<=result, out_valid<=1, shift smp into history -> OUT.
//   OUT: out_valid=1; out_data stable. On out_ready -> out_valid<=0 -> IDLE.
//  Latency: accept edge to out_valid = ORDER+1 cycles. Max throughput: 1 sample per ORDER+2 cycles.
//  Backpressure: OUT holds indefinitely. in_ready stays 0 and no sample is dropped or overwritten.
//  History updates once per completed sample. Samples aborted by reset never enter the history.
//  Coef writes: honoured only in IDLE; ignored in MAC/OUT.
//   A write and an accept in the same IDLE cycle: the new value is used for that sample.
//   coef_addr >= ORDER is ignored.
//  Reset mid-MAC or mid-OUT: sample discarded, out_valid drops asynchronously, history cleared.
//   First sample after reset returns x=y.
//  in_valid while not in IDLE: ignored (no accept).
// STRUCTURE
//  Package iir_pkg: state enum {IDLE,MAC,OUT}, DATA_W default, MAX_ORDER=8.
//  Sub-module signed_mult: combinational Baugh-Wooley DATA_W x DATA_W -> 2*DATA_W.
//   Single instance, tap selected by mux.
//  Top: FSM, tap counter, accumulator, history shift register, coefficient register file.
// TESTING
//  ORDER=1, a_1=3, y=1,5,2 (IIR output of x=1,2,3) -> out_data=1,2,3.
//   Each out_valid 2 cycles after accept.
//  ORDER=1, a_1=0xE (-2), y=1,0xF -> out_data=1,1. Covers negative coefficient and wrap.
//  ORDER=2, a=(1,1), y=1,1,1 -> out_data=1,0,0xF.
//  Backpressure: out_ready=0 for 5 cycles in OUT -> out_valid=1, out_data stable, in_ready=0.
//   Then 1 transfer only.
//  Reset asserted in MAC cycle 1 -> out_valid=0 same cycle, no output.
//   Next y=7 -> out_data=7.
//  Coef write during MAC -> ignored: old coefficient still used.
//   Write + accept in the same IDLE cycle -> new coefficient used.
//   Random y vs reference model for 1000 samples.

Source files
------------

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types and constants for the inverse IIR (all-zero) filter
// Purpose: FSM state encoding and sizing constants shared by the filter files.
// Ports: none (package).
package iir_pkg;

    localparam int IIR_DATA_W = 4;
    localparam int MAX_ORDER  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } iir_state_e;

endpackage

// File: rtl/iir_inverse_fir_signed_mult.sv
// rtl/iir_inverse_fir_signed_mult.sv - combinational Baugh-Wooley signed multiplier
// Purpose: full-precision W x W two's complement product.
// Ports:
//   a  in  W    signed multiplicand
//   b  in  W    signed multiplier
//   p  out 2*W  signed product
module signed_mult #(
    parameter int W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    // Modified Baugh-Wooley: partial products that pair exactly one sign bit
    // are inverted, and the correction constant 2^W + 2^(2W-1) is added.
    always_comb begin
        logic pp;
        p  = '0;
        pp = 1'b0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                pp = a[j] & b[i];
                if ((i == W - 1) != (j == W - 1)) begin
                    pp = ~pp;
                end
                p = p + ((2*W)'(pp) << (i + j));
            end
        end
        p = p + ((2*W)'(1) << W) + ((2*W)'(1) << (2*W - 1));
    end

endmodule

// File: rtl/iir_inverse_fir.sv
// rtl/iir_inverse_fir.sv - inverse (all-zero) filter undoing the recursive IIR stage
// Purpose: x[n] = y[n] - sum_{k=1..ORDER} a_k*y[n-k], mod 2^DATA_W, one tap per cycle
//          through a single shared multiplier.
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       async active-high reset
//   coef_we    in   1       coefficient write strobe (honoured in IDLE only)
//   coef_addr  in   AW      tap index: 0 -> a_1 ... ORDER-1 -> a_ORDER
//   coef_data  in   DATA_W  coefficient value
//   in_valid   in   1       y sample present
//   in_ready   out  1       block can accept a sample
//   in_data    in   DATA_W  y[n]
//   out_valid  out  1       recovered x[n] present
//   out_ready  in   1       sink accepts x[n]
//   out_data   out  DATA_W  x[n]
module iir_inverse_fir
    import iir_pkg::*;
#(
    parameter int DATA_W = IIR_DATA_W,
    parameter int ORDER  = 2,
    parameter int AW     = (ORDER > 1) ? $clog2(ORDER) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [DATA_W-1:0] coef_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int KW = 4;
    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_MAC  = 2'(MAC);
    localparam logic [1:0] ST_OUT  = 2'(OUT);

    logic [1:0]          state;
    logic [KW-1:0]       k;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   smp;
    logic [DATA_W-1:0]   hist [1:ORDER];
    logic [DATA_W-1:0]   coef [0:ORDER-1];

    logic [DATA_W-1:0]   coef_sel;
    logic [DATA_W-1:0]   hist_sel;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   acc_next;
    logic                prod_hi_unused;

    assign in_ready = (state == ST_IDLE);

    // Tap mux feeding the shared multiplier: tap k pairs a_k with y[n-k].
    always_comb begin
        coef_sel = '0;
        hist_sel = '0;
        for (int i = 1; i <= ORDER; i++) begin
            if (k == KW'(i)) begin
                coef_sel = coef[i-1];
                hist_sel = hist[i];
            end
        end
    end

    signed_mult #(
        .W (DATA_W)
    ) u_mult (
        .a (coef_sel),
        .b (hist_sel),
        .p (prod)
    );

    // Only the low half of the product matters: it is the same for signed
    // and unsigned interpretation, and matches the IIR stage's truncation.
    assign acc_next       = acc - prod[DATA_W-1:0];
    assign prod_hi_unused = ^prod[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            k         <= '0;
            acc       <= '0;
            smp       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 1; i <= ORDER; i++) begin
                hist[i] <= '0;
            end
            for (int i = 0; i < ORDER; i++) begin
                coef[i] <= '0;
            end
        end else begin
            // Writes land before the first MAC cycle, so a write in the same
            // cycle as an accept already applies to that sample.
            if (state == ST_IDLE && coef_we) begin
                for (int i = 0; i < ORDER; i++) begin
                    if (coef_addr == AW'(i)) begin
                        coef[i] <= coef_data;
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        smp   <= in_data;
                        acc   <= in_data;
                        k     <= KW'(1);
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc_next;
                    if (k == KW'(ORDER)) begin
                        out_data  <= acc_next;
                        out_valid <= 1'b1;
                        hist[1]   <= smp;
                        for (int i = 2; i <= ORDER; i++) begin
                            hist[i] <= hist[i-1];
                        end
                        state <= ST_OUT;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_inverse_fir.sv
// tb/tb_iir_inverse_fir.sv - self-checking bench for iir_inverse_fir (ORDER=1 and ORDER=2)
module tb_iir_inverse_fir;

    logic       clk;
    logic       rst;
    logic       sel;
    logic       coef_we;
    logic [0:0] coef_addr;
    logic [3:0] coef_data;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;

    logic       we1, we2, iv1, iv2;
    logic       rdy1, rdy2, ov1, ov2;
    logic [3:0] od1, od2;
    logic       cur_ready, cur_ov;
    logic [3:0] cur_od;

    int         passed;
    int         failed;
    int         total;
    logic [3:0] exp_q [$];
    int         mh [1:2];
    int         mc [0:1];

    assign we1 = coef_we & ~sel;
    assign we2 = coef_we & sel;
    assign iv1 = in_valid & ~sel;
    assign iv2 = in_valid & sel;
    assign cur_ready = sel ? rdy2 : rdy1;
    assign cur_ov    = sel ? ov2 : ov1;
    assign cur_od    = sel ? od2 : od1;

    iir_inverse_fir #(.DATA_W(4), .ORDER(1)) dut1 (
        .clk(clk), .rst(rst), .coef_we(we1), .coef_addr(coef_addr),
        .coef_data(coef_data), .in_valid(iv1), .in_ready(rdy1),
        .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1)
    );

    iir_inverse_fir #(.DATA_W(4), .ORDER(2)) dut2 (
        .clk(clk), .rst(rst), .coef_we(we2), .coef_addr(coef_addr),
        .coef_data(coef_data), .in_valid(iv2), .in_ready(rdy2),
        .in_data(in_data), .out_valid(ov2), .out_ready(out_ready),
        .out_data(od2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [0:0] addr, input logic [3:0] data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // mode 0: plain; 1: coef a_1 write with the accept; 2: coef a_1 write in MAC cycle 1
    task automatic send(input logic [3:0] y, input logic [3:0] exp, input int hold,
                        input int mode, input logic [3:0] wdata, input int lat_exp);
        int n;
        int lat;
        logic [3:0] got;
        logic [3:0] want;
        exp_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = y;
        if (hold > 0) out_ready = 1'b0;
        if (mode == 1) begin
            coef_we = 1'b1; coef_addr = 1'b0; coef_data = wdata;
        end
        n = 0;
        while (!cur_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 8'd0, 8'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        if (mode == 2) begin
            coef_we = 1'b1; coef_addr = 1'b0; coef_data = wdata;
        end
        lat = 1;
        while (!cur_ov && lat < 50) begin
            @(negedge clk);
            coef_we = 1'b0;
            lat++;
        end
        coef_we = 1'b0;
        check("latency", 8'(lat), 8'(lat_exp));
        got = cur_od;
        if (exp_q.size() == 0) begin
            check("queue_empty", 8'd0, 8'd1);
        end else begin
            want = exp_q.pop_front();
            check("out_data", 8'(got), 8'(want));
        end
        if (hold > 0) begin
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                check("bp_out_valid", 8'(cur_ov), 8'd1);
                check("bp_out_data", 8'(cur_od), 8'(got));
                check("bp_in_ready", 8'(cur_ready), 8'd0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("bp_single_transfer", 8'(cur_ov), 8'd0);
        end else begin
            @(posedge clk);
        end
    endtask

    function automatic logic [3:0] model(input int y);
        int t;
        logic [31:0] tv;
        t = y;
        for (int k = 1; k <= 2; k++) t = t - mc[k-1] * mh[k];
        mh[2] = mh[1];
        mh[1] = y;
        tv = 32'(t);
        return tv[3:0];
    endfunction

    initial begin
        int bad;
        int y;
        passed = 0; failed = 0; total = 0;
        rst = 1'b1; sel = 1'b0; coef_we = 1'b0; coef_addr = 1'b0; coef_data = 4'h0;
        in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid1", 8'(ov1), 8'd0);
        check("rst_out_data1", 8'(od1), 8'd0);
        check("rst_in_ready1", 8'(rdy1), 8'd1);
        check("rst_out_valid2", 8'(ov2), 8'd0);
        check("rst_in_ready2", 8'(rdy2), 8'd1);

        // ORDER=1, a_1=3; out-of-range address write must be ignored
        sel = 1'b0;
        wr(1'b0, 4'h3);
        wr(1'b1, 4'h5);
        send(4'h1, 4'h1, 0, 0, 4'h0, 2);
        send(4'h5, 4'h2, 0, 0, 4'h0, 2);
        send(4'h2, 4'h3, 0, 0, 4'h0, 2);

        // ORDER=1, a_1=-2 with wrap
        do_reset();
        wr(1'b0, 4'hE);
        send(4'h1, 4'h1, 0, 0, 4'h0, 2);
        send(4'hF, 4'h1, 0, 0, 4'h0, 2);

        // coef write in MAC ignored; write with accept takes effect
        do_reset();
        wr(1'b0, 4'h3);
        send(4'h1, 4'h1, 0, 0, 4'h0, 2);
        send(4'h5, 4'h2, 0, 2, 4'h7, 2);
        send(4'h2, 4'hD, 0, 1, 4'h1, 2);

        // ORDER=2, a=(1,1)
        sel = 1'b1;
        do_reset();
        wr(1'b0, 4'h1);
        wr(1'b1, 4'h1);
        send(4'h1, 4'h1, 0, 0, 4'h0, 3);
        send(4'h1, 4'h0, 0, 0, 4'h0, 3);
        send(4'h1, 4'hF, 0, 0, 4'h0, 3);
        send(4'h3, 4'h1, 5, 0, 4'h0, 3);

        // reset during MAC cycle 1
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'h9;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mac_out_valid", 8'(cur_ov), 8'd0);
        check("rst_mac_in_ready", 8'(cur_ready), 8'd1);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (cur_ov) bad++;
        end
        check("rst_no_output", 8'(bad), 8'd0);
        wr(1'b0, 4'h1);
        wr(1'b1, 4'h1);
        send(4'h7, 4'h7, 0, 0, 4'h0, 3);

        // random samples against reference model
        do_reset();
        mh[1] = 0; mh[2] = 0;
        mc[0] = int'($urandom_range(0, 15));
        mc[1] = int'($urandom_range(0, 15));
        wr(1'b0, 4'(mc[0]));
        wr(1'b1, 4'(mc[1]));
        for (int i = 0; i < 1000; i++) begin
            y = int'($urandom_range(0, 15));
            send(4'(y), model(y), 0, 0, 4'h0, 3);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
